// File: rtl/sd_pkg.sv
// Shared definitions for the SD receive path: FSM encoding and data widths.
package sd_pkg;
  localparam int SD_NIB_W       = 4;
  localparam int SD_WORD_W      = 32;
  localparam int SD_BLOCK_WORDS = 128;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'b001,
    ST_COLLECT = 3'b010,
    ST_DRAIN   = 3'b100
  } sd_rx_state_e;
endpackage

// File: rtl/sd_rx_hold_reg.sv
// Single-entry holding register between the word packer and the RX FIFO.
// Loads a completed word, drains it when the FIFO is not full, flags drops.
module sd_rx_hold_reg
  import sd_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_clr,
  input  logic                 i_load,
  input  logic [SD_WORD_W-1:0] i_data,
  input  logic                 i_full,
  output logic                 o_valid,
  output logic [SD_WORD_W-1:0] o_data,
  output logic                 o_drain,
  output logic                 o_drop
);
  logic                 r_valid;
  logic [SD_WORD_W-1:0] r_data;

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_drain = r_valid & ~i_full;
  // A new word is lost only if the old one cannot leave this cycle.
  assign o_drop  = i_load & r_valid & i_full;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_load && !o_drop) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (o_drain) begin
      r_valid <= 1'b0;
    end
  end
endmodule

// File: rtl/sd_rx_word_packer.sv
// Packs SD DAT nibbles into 32-bit RX FIFO words, one block per xfer_start.
// SD_RX_BIG_ENDIAN_EN: first nibble lands in [31:28] instead of [3:0].
module sd_rx_word_packer
  import sd_pkg::*;
#(
  parameter int BLOCK_WORDS = SD_BLOCK_WORDS,
  parameter int CNT_W       = $clog2(BLOCK_WORDS + 1)
) (
  input  logic                 sd_clk,
  input  logic                 rst,
  input  logic                 xfer_start,
  input  logic [SD_NIB_W-1:0]  nib_in,
  input  logic                 nib_we,
  output logic [SD_WORD_W-1:0] fifo_data,
  output logic                 fifo_wr,
  input  logic                 fifo_full,
  output logic [CNT_W-1:0]     word_cnt,
  output logic                 block_done,
  output logic                 overflow,
  output logic                 busy
);
  sd_rx_state_e         r_state, w_state_nxt;
  logic [2:0]           r_nib_cnt;
  logic [CNT_W-1:0]     r_acc_cnt;
  logic [CNT_W-1:0]     r_word_cnt;
  logic [SD_WORD_W-1:0] r_shift, w_shift_nxt;
  logic [SD_WORD_W-1:0] r_fifo_data;
  logic                 r_fifo_wr, r_block_done, r_overflow;
  logic                 w_nib_acc, w_word_done, w_last_word;
  logic                 w_hold_valid, w_drain, w_drop;
  logic [SD_WORD_W-1:0] w_hold_data;

  assign w_nib_acc   = (r_state == ST_COLLECT) && nib_we && !xfer_start;
  assign w_word_done = w_nib_acc && (r_nib_cnt == 3'd7);
  // Dropped words count as accepted so a lossy block still terminates.
  assign w_last_word = w_word_done && (r_acc_cnt == CNT_W'(BLOCK_WORDS - 1));

`ifdef SD_RX_BIG_ENDIAN_EN
  assign w_shift_nxt = {r_shift[SD_WORD_W-SD_NIB_W-1:0], nib_in};
`else
  assign w_shift_nxt = {nib_in, r_shift[SD_WORD_W-1:SD_NIB_W]};
`endif

  sd_rx_hold_reg u_hold (
    .i_clk   (sd_clk),
    .i_rst   (rst),
    .i_clr   (xfer_start),
    .i_load  (w_word_done),
    .i_data  (w_shift_nxt),
    .i_full  (fifo_full),
    .o_valid (w_hold_valid),
    .o_data  (w_hold_data),
    .o_drain (w_drain),
    .o_drop  (w_drop)
  );

  always_ff @(posedge sd_clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (xfer_start) begin
      w_state_nxt = ST_COLLECT;
    end else begin
      case (r_state)
        ST_COLLECT: if (w_last_word)   w_state_nxt = ST_DRAIN;
        ST_DRAIN:   if (!w_hold_valid) w_state_nxt = ST_IDLE;
        default:    w_state_nxt = r_state;
      endcase
    end
  end

  always_ff @(posedge sd_clk) begin
    if (rst || xfer_start) begin
      r_nib_cnt    <= '0;
      r_acc_cnt    <= '0;
      r_word_cnt   <= '0;
      r_shift      <= '0;
      r_fifo_data  <= '0;
      r_fifo_wr    <= 1'b0;
      r_block_done <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_fifo_wr <= w_drain;
      if (w_drain) begin
        r_fifo_data <= w_hold_data;
        if (r_word_cnt != CNT_W'(BLOCK_WORDS)) r_word_cnt <= r_word_cnt + CNT_W'(1);
      end
      if (w_nib_acc) begin
        r_shift   <= w_shift_nxt;
        r_nib_cnt <= r_nib_cnt + 3'd1;
      end
      if (w_word_done) r_acc_cnt <= r_acc_cnt + CNT_W'(1);
      if (w_drop) r_overflow <= 1'b1;
      if (r_state == ST_DRAIN && !w_hold_valid) r_block_done <= 1'b1;
    end
  end

  assign fifo_data  = r_fifo_data;
  assign fifo_wr    = r_fifo_wr;
  assign word_cnt   = r_word_cnt;
  assign block_done = r_block_done;
  assign overflow   = r_overflow;
  assign busy       = (r_state != ST_IDLE);
endmodule
